// File: rtl/seq_mult_w_if.sv
// seq_mult_w_if: start/done multiplier handshake bundle.
interface seq_mult_w_if #(parameter int WIDTH = 8) ();
    logic                 start;
    logic                 sgn;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   d_out;
    logic                 done;
    logic                 busy;
    modport master (output start, sgn, a, b, input d_out, done, busy);
    modport slave  (input start, sgn, a, b, output d_out, done, busy);
endinterface

// File: rtl/seq_mult_w.sv
// seq_mult_w: sequential shift-and-add multiplier, signed/unsigned, any WIDTH.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_w #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_mult_w_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt, d_out;
    logic [WIDTH-1:0]   mplier, mplier_nxt, mag_a, mag_b;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               flip, done, busy, last;

    // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
    always_comb begin
        mag_a      = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b      = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        acc_nxt    = mplier[0] ? acc + mcand : acc;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 1'b1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last       = (cnt_nxt == LAST) || (mplier_nxt == '0);
`else
        last       = cnt_nxt == LAST;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            flip   <= 1'b0;
            d_out  <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mplier <= mag_b;
                    flip   <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= CALC;
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt_nxt;
                    if (last) begin
                        d_out <= flip ? -acc_nxt : acc_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.d_out = d_out;
    assign bus.done  = done;
    assign bus.busy  = busy;
endmodule
